// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int MID_TICK_DEF   = OVERSAMPLE_DEF / 2 - 1;
   localparam int NBITS_MIN      = 5;

   // Tick index of the start-bit midpoint for a given oversampling ratio
   function automatic int mid_tick(input int os);
      return os / 2 - 1;
   endfunction

   // Out-of-range frame lengths fall back to the full data width
   function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int data_w);
      if (int'(n) < NBITS_MIN || int'(n) > data_w)
         return 4'(data_w);
      return n;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver control/status bundle
interface uart_rx_if #(
   parameter int DATA_W = 8
);
   logic              Tick;
   logic [3:0]        NBits;
   logic              Rx;
   logic [DATA_W-1:0] RxData;
   logic              RxDone;
   logic              FrameErr;
   logic              Busy;

   modport master (
      output Tick, NBits, Rx,
      input  RxData, RxDone, FrameErr, Busy
   );

   modport slave (
      input  Tick, NBits, Rx,
      output RxData, RxDone, FrameErr, Busy
   );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset level
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 5..DATA_W data bits, one stop bit
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_W     = 8
) (
   input logic       Clk,
   input logic       Rst,
   uart_rx_if.slave  bus
);
   localparam int            TW      = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TC_MID  = TW'(mid_tick(OVERSAMPLE));
   localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);

   uart_state_t       r_state;
   uart_state_t       w_next;
   logic              w_rx;
   logic [TW-1:0]     r_tcnt;
   logic [3:0]        r_bitcnt;
   logic [3:0]        r_nbits;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] r_data;
   logic              r_done;
   logic              r_ferr;
   logic              w_tc_mid;
   logic              w_tc_last;
   logic              w_last_bit;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .i_clk (Clk),
      .i_rst (Rst),
      .i_d   (bus.Rx),
      .o_q   (w_rx)
   );

   assign w_tc_mid   = (r_tcnt == TC_MID);
   assign w_tc_last  = (r_tcnt == TC_LAST);
   assign w_last_bit = (r_bitcnt == r_nbits - 4'd1);

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state decisions are taken only on baud ticks
   always_comb begin
      w_next = r_state;
      if (bus.Tick) begin
         case (r_state)
            IDLE:    if (!w_rx)     w_next = START;
            START:   if (w_tc_mid)  w_next = w_rx ? IDLE : DATA;
            DATA:    if (w_tc_last && w_last_bit) w_next = STOP;
            STOP:    if (w_tc_last) w_next = w_rx ? IDLE : BREAK;
            BREAK:   if (w_rx)      w_next = IDLE;
            default:                w_next = IDLE;
         endcase
      end
   end

   // Datapath: tick/bit counters, shifter, result word and one-cycle strobes
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_tcnt   <= '0;
         r_bitcnt <= '0;
         r_nbits  <= '0;
         r_shreg  <= '0;
         r_data   <= '0;
         r_done   <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ferr <= 1'b0;
         if (bus.Tick) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx) begin
                     r_tcnt  <= '0;
                     r_nbits <= clamp_nbits(bus.NBits, DATA_W);
                  end
               end
               START: begin
                  if (w_tc_mid) begin
                     r_tcnt   <= '0;
                     r_bitcnt <= '0;
                     r_shreg  <= '0;
                  end else begin
                     r_tcnt <= r_tcnt + TW'(1);
                  end
               end
               DATA: begin
                  if (w_tc_last) begin
                     // LSB arrives first, so new bits enter at the top and walk down
                     r_shreg  <= {w_rx, r_shreg[DATA_W-1:1]};
                     r_bitcnt <= r_bitcnt + 4'd1;
                     r_tcnt   <= '0;
                  end else begin
                     r_tcnt <= r_tcnt + TW'(1);
                  end
               end
               STOP: begin
                  if (w_tc_last) begin
                     r_tcnt <= '0;
                     if (w_rx) begin
                        r_data <= r_shreg >> (4'(DATA_W) - r_nbits);
                        r_done <= 1'b1;
                     end else begin
                        r_ferr <= 1'b1;
                     end
                  end else begin
                     r_tcnt <= r_tcnt + TW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      bus.Busy     = (r_state != IDLE);
      bus.RxDone   = r_done;
      bus.FrameErr = r_ferr;
      bus.RxData   = r_data;
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
   logic Clk = 1'b0;
   logic Rst = 1'b1;

   uart_rx_if #(.DATA_W(8)) bus ();

   uart_rx #(.OVERSAMPLE(16), .DATA_W(8)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   int div   = 4;
   int cyc   = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   logic [7:0] exp_q[$];
   int done_cyc[$];
   logic prev_busy = 1'b0;
   logic prev_done = 1'b0;
   logic prev_ferr = 1'b0;

   typedef struct {
      int         nbits_cfg;
      int         nsend;
      logic [7:0] data;
      int         tdiv;
      logic [7:0] expd;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_bits(input int n);
      repeat (n * 16 * div) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int n, input logic stop_v);
      bus.Rx = 1'b0;
      wait_bits(1);
      for (int i = 0; i < n; i++) begin
         bus.Rx = d[i];
         wait_bits(1);
      end
      bus.Rx = stop_v;
      wait_bits(1);
   endtask

   // Baud tick source: one-cycle pulse every div clocks (constant high when div is 1)
   initial begin
      int c;
      c = 0;
      bus.Tick = 1'b0;
      forever begin
         @(negedge Clk);
         c = (c + 1) % div;
         bus.Tick = (c == 0);
      end
   end

   // Output monitor and scoreboard consumer
   initial begin
      forever begin
         @(negedge Clk);
         cyc++;
         if (!Rst) begin
            if (bus.RxDone) begin
               done_cnt++;
               done_cyc.push_back(cyc);
               check("busy_low_at_done", 32'(bus.Busy), 0);
               check("busy_high_before_done", 32'(prev_busy), 1);
               check("done_excl_ferr", 32'(bus.FrameErr), 0);
               check("done_width", 32'(prev_done), 0);
               check("sb_has_entry", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0)
                  check("rxdata_sb", 32'(bus.RxData), 32'(exp_q.pop_front()));
            end
            if (bus.FrameErr) begin
               ferr_cnt++;
               check("ferr_width", 32'(prev_ferr), 0);
            end
         end
         prev_busy = bus.Busy;
         prev_done = bus.RxDone;
         prev_ferr = bus.FrameErr;
      end
   end

   initial begin
      int d0;
      int f0;
      int diff;
      int n;
      logic [7:0] rd0;

      vecs[0] = '{8,  8, 8'hA5, 4, 8'hA5};
      vecs[1] = '{5,  5, 8'h15, 4, 8'h15};
      vecs[2] = '{12, 8, 8'hC3, 4, 8'hC3};
      vecs[3] = '{7,  7, 8'hDA, 4, 8'h5A};
      vecs[4] = '{8,  8, 8'h96, 1, 8'h96};
      vecs[5] = '{6,  6, 8'h2B, 2, 8'h2B};
      vecs[6] = '{0,  8, 8'h4E, 4, 8'h4E};

      bus.Rx    = 1'b1;
      bus.NBits = 4'd8;
      Rst       = 1'b1;
      repeat (3) @(negedge Clk);
      check("rst_rxdata", 32'(bus.RxData), 0);
      check("rst_rxdone", 32'(bus.RxDone), 0);
      check("rst_ferr", 32'(bus.FrameErr), 0);
      check("rst_busy", 32'(bus.Busy), 0);
      Rst = 1'b0;
      repeat (20) @(negedge Clk);

      // Clean frames across widths and tick spacings
      for (int i = 0; i < 7; i++) begin
         div = vecs[i].tdiv;
         bus.NBits = 4'(vecs[i].nbits_cfg);
         wait_bits(1);
         d0 = done_cnt;
         f0 = ferr_cnt;
         exp_q.push_back(vecs[i].expd);
         send_frame(vecs[i].data, vecs[i].nsend, 1'b1);
         wait_bits(2);
         check("vec_sb_drained", 32'(exp_q.size()), 0);
         check("vec_rxdata", 32'(bus.RxData), 32'(vecs[i].expd));
         check("vec_done_count", 32'(done_cnt - d0), 1);
         check("vec_no_ferr", 32'(ferr_cnt - f0), 0);
      end

      // Glitch on the line shorter than half a bit
      div = 4;
      bus.NBits = 4'd8;
      wait_bits(1);
      d0  = done_cnt;
      f0  = ferr_cnt;
      rd0 = bus.RxData;
      bus.Rx = 1'b0;
      repeat (12) @(negedge Clk);
      check("glitch_busy_rise", 32'(bus.Busy), 1);
      repeat (4) @(negedge Clk);
      bus.Rx = 1'b1;
      wait_bits(3);
      check("glitch_busy_idle", 32'(bus.Busy), 0);
      check("glitch_no_done", 32'(done_cnt - d0), 0);
      check("glitch_no_ferr", 32'(ferr_cnt - f0), 0);
      check("glitch_rxdata", 32'(bus.RxData), 32'(rd0));

      // Stop bit low, line held low for three more bits
      d0  = done_cnt;
      f0  = ferr_cnt;
      rd0 = bus.RxData;
      send_frame(8'h3C, 8, 1'b0);
      wait_bits(3);
      check("break_busy", 32'(bus.Busy), 1);
      check("break_ferr_once", 32'(ferr_cnt - f0), 1);
      check("break_no_done", 32'(done_cnt - d0), 0);
      bus.Rx = 1'b1;
      wait_bits(2);
      check("break_busy_idle", 32'(bus.Busy), 0);
      check("break_rxdata_kept", 32'(bus.RxData), 32'(rd0));
      check("break_no_done_after", 32'(done_cnt - d0), 0);
      check("break_ferr_total", 32'(ferr_cnt - f0), 1);

      // Back-to-back frames with no idle gap
      d0 = done_cnt;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 8, 1'b1);
      exp_q.push_back(8'hAA);
      send_frame(8'hAA, 8, 1'b1);
      wait_bits(2);
      check("b2b_done_count", 32'(done_cnt - d0), 2);
      check("b2b_sb_drained", 32'(exp_q.size()), 0);
      n = done_cyc.size();
      diff = (n >= 2) ? done_cyc[n-1] - done_cyc[n-2] : 0;
      total++;
      if (diff < 636 || diff > 644) begin
         bad++;
         $display("FAIL b2b_spacing: actual=%0d cycles required=636..644", diff);
      end

      // Reset during bit 3 of 0xFF, then a clean frame
      check("pre_rst_rxdata", 32'(bus.RxData), 32'h0AA);
      bus.Rx = 1'b0;
      wait_bits(1);
      for (int i = 0; i < 3; i++) begin
         bus.Rx = 1'b1;
         wait_bits(1);
      end
      bus.Rx = 1'b1;
      repeat (32) @(negedge Clk);
      check("mid_busy_before_rst", 32'(bus.Busy), 1);
      Rst = 1'b1;
      #1;
      check("midrst_rxdata", 32'(bus.RxData), 0);
      check("midrst_busy", 32'(bus.Busy), 0);
      check("midrst_rxdone", 32'(bus.RxDone), 0);
      check("midrst_ferr", 32'(bus.FrameErr), 0);
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      wait_bits(2);
      check("post_rst_busy", 32'(bus.Busy), 0);
      d0 = done_cnt;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 8, 1'b1);
      wait_bits(2);
      check("post_rst_rxdata", 32'(bus.RxData), 32'h081);
      check("post_rst_done", 32'(done_cnt - d0), 1);
      check("post_rst_drained", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
